// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the frame capture sequencer: state encoding,
// capture mode constants and the default watchdog period.
package capture_seq_pkg;

   // The encoding is visible on oSTATE, so the values are fixed.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SYNC   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_GAP    = 3'd4,
      ST_FAULT  = 3'd5
   } state_e;

   // Continuous runs until halted; burst stops after a preset frame count.
   localparam logic MODE_CONT  = 1'b0;
   localparam logic MODE_BURST = 1'b1;

   // Cycles without any frame-valid edge before the sensor is declared stalled.
   localparam int DEFAULT_TIMEOUT_CYC = 1048576;

endpackage

// File: rtl/capture_sequencer_fval_edge_det.sv
// Frame-valid edge detector. iFVAL is already registered in the iCLK
// domain, so one more flop gives the previous value for edge detection.
module fval_edge_det (
   input  logic iCLK,
   input  logic iRST,
   input  logic iFVAL,
   output logic oRISE,
   output logic oFALL
);

   logic fval_dly_q;

   // Previous-cycle copy of frame valid; cleared by reset.
   always_ff @(posedge iCLK) begin
      if (iRST) fval_dly_q <= 1'b0;
      else      fval_dly_q <= iFVAL;
   end

   assign oRISE = iFVAL & ~fval_dly_q;
   assign oFALL = ~iFVAL & fval_dly_q;

endmodule

// File: rtl/capture_sequencer.sv
// Frame-level capture controller. Aligns run/snapshot/halt commands to
// frame boundaries, drives the capture enable and buffer reload strobe,
// counts completed frames and faults on a stalled sensor.
// Commands (iRUN, iSNAP, iHALT) are single-cycle pulses with no
// handshake: a pulse not accepted in the cycle it arrives is dropped.
module capture_sequencer
   import capture_seq_pkg::*;
#(
   parameter int LOAD_PULSE_LEN = 4,
   parameter int BURST_W        = 8,
   parameter int FRAME_CNT_W    = 16,
   parameter int TIMEOUT_CYC    = DEFAULT_TIMEOUT_CYC
) (
   input  logic                   iCLK,
   input  logic                   iRST,
   input  logic                   iFVAL,
   input  logic                   iRUN,
   input  logic                   iSNAP,
   input  logic [BURST_W-1:0]     iBURST_N,
   input  logic                   iHALT,
   output logic                   oCAP_EN,
   output logic                   oLOAD,
   output logic [FRAME_CNT_W-1:0] oFRAME_CNT,
   output logic                   oBUSY,
   output logic                   oDONE,
   output logic                   oTIMEOUT,
   output logic [2:0]             oSTATE
);

   localparam int LOAD_W = $clog2(LOAD_PULSE_LEN + 1);
   localparam int WD_W   = $clog2(TIMEOUT_CYC);
   localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_PULSE_LEN - 1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);

   logic rise, fall;

   state_e                 state_q, state_d;
   logic                   mode_q, mode_d;
   logic [BURST_W-1:0]     rem_q, rem_d;
   logic                   halt_pend_q, halt_pend_d;
   logic [LOAD_W-1:0]      load_cnt_q, load_cnt_d;
   logic [WD_W-1:0]        wd_q, wd_d;
   logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
   logic                   cap_en_q, cap_en_d;
   logic                   load_q, load_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   timeout_q, timeout_d;

   fval_edge_det u_edge (
      .iCLK  (iCLK),
      .iRST  (iRST),
      .iFVAL (iFVAL),
      .oRISE (rise),
      .oFALL (fall)
   );

   // State, counters and registered outputs; reset clears everything.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_CONT;
         rem_q       <= '0;
         halt_pend_q <= 1'b0;
         load_cnt_q  <= '0;
         wd_q        <= '0;
         cnt_q       <= '0;
         cap_en_q    <= 1'b0;
         load_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         rem_q       <= rem_d;
         halt_pend_q <= halt_pend_d;
         load_cnt_q  <= load_cnt_d;
         wd_q        <= wd_d;
         cnt_q       <= cnt_d;
         cap_en_q    <= cap_en_d;
         load_q      <= load_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state logic; level outputs are decoded from the next state so
   // they change in the same cycle as oSTATE.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      rem_d       = rem_q;
      halt_pend_d = halt_pend_q;
      load_cnt_d  = load_cnt_q;
      wd_d        = wd_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      timeout_d   = timeout_q;

      unique case (state_q)
         ST_IDLE, ST_FAULT: begin
            // Snapshot beats run; a zero-length snapshot is not a start.
            if (iSNAP && (iBURST_N != '0)) begin
               state_d     = ST_LOAD;
               mode_d      = MODE_BURST;
               rem_d       = iBURST_N;
               load_cnt_d  = '0;
               halt_pend_d = 1'b0;
               timeout_d   = 1'b0;
            end else if (iRUN) begin
               state_d     = ST_LOAD;
               mode_d      = MODE_CONT;
               load_cnt_d  = '0;
               halt_pend_d = 1'b0;
               timeout_d   = 1'b0;
            end
         end

         ST_LOAD: begin
            if (iHALT) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (load_cnt_q == LOAD_LAST) begin
               state_d = ST_SYNC;
               wd_d    = '0;
            end else begin
               load_cnt_d = load_cnt_q + LOAD_W'(1);
            end
         end

         ST_SYNC, ST_GAP: begin
            // Only a true rising edge starts a frame, so a frame already
            // in progress when SYNC is entered is skipped.
            if (iHALT) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (rise) begin
               state_d = ST_ACTIVE;
               wd_d    = '0;
            end else if (fall) begin
               wd_d = '0;
            end else if (wd_q == WD_LAST) begin
               state_d   = ST_FAULT;
               timeout_d = 1'b1;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end

         ST_ACTIVE: begin
            // A halt here only takes effect at the end of the frame.
            if (fall) begin
               cnt_d = cnt_q + FRAME_CNT_W'(1);
               if (mode_q == MODE_BURST) rem_d = rem_q - BURST_W'(1);
               if (halt_pend_q || iHALT ||
                   ((mode_q == MODE_BURST) && (rem_q == BURST_W'(1)))) begin
                  state_d     = ST_IDLE;
                  done_d      = 1'b1;
                  halt_pend_d = 1'b0;
               end else begin
                  state_d = ST_GAP;
                  wd_d    = '0;
               end
            end else if (iHALT) begin
               halt_pend_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      cap_en_d = (state_d == ST_ACTIVE) || (state_d == ST_GAP);
      load_d   = (state_d == ST_LOAD);
      busy_d   = (state_d == ST_LOAD) || (state_d == ST_SYNC) ||
                 (state_d == ST_ACTIVE) || (state_d == ST_GAP);
   end

   assign oCAP_EN    = cap_en_q;
   assign oLOAD      = load_q;
   assign oFRAME_CNT = cnt_q;
   assign oBUSY      = busy_q;
   assign oDONE      = done_q;
   assign oTIMEOUT   = timeout_q;
   assign oSTATE     = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: directed scenarios with
// explicit expectations plus a randomized run against a frame-level model.
module tb_capture_sequencer;

  localparam int LOAD_LEN = 4;
  localparam int TO_CYC   = 64;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, fval, run, snap, halt;
  logic [7:0]  burst_n;
  logic        cap_en, load, busy, done, timeout;
  logic [15:0] frame_cnt;
  logic [2:0]  state;

  always #5 clk = ~clk;

  capture_sequencer #(
    .LOAD_PULSE_LEN (LOAD_LEN),
    .BURST_W        (8),
    .FRAME_CNT_W    (16),
    .TIMEOUT_CYC    (TO_CYC)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iFVAL      (fval),
    .iRUN       (run),
    .iSNAP      (snap),
    .iBURST_N   (burst_n),
    .iHALT      (halt),
    .oCAP_EN    (cap_en),
    .oLOAD      (load),
    .oFRAME_CNT (frame_cnt),
    .oBUSY      (busy),
    .oDONE      (done),
    .oTIMEOUT   (timeout),
    .oSTATE     (state)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;
  int          done_seen;
  bit          busy_dropped;

  // ---------------- reference model ----------------
  // Phase-level view of the sequencer: which part of the capture cycle we
  // are in, plus countdowns (load cycles left, frames left, quiet cycles).
  localparam int P_IDLE = 0, P_LOAD = 1, P_SYNC = 2, P_ACT = 3, P_GAP = 4, P_FAULT = 5;
  int          m_ph = P_IDLE;
  int          m_load_left = 0;
  int          m_quiet = 0;
  int          m_left = 0;
  bit          m_burst = 0;
  bit          m_hp = 0;
  bit          m_fv = 0;
  logic [15:0] m_cnt = '0;
  bit          m_done = 0;
  bit          m_to = 0;

  task automatic m_start(input bit burst, input int frames);
    m_ph = P_LOAD; m_load_left = LOAD_LEN; m_burst = burst; m_left = frames;
    m_hp = 0; m_to = 0;
  endtask

  task automatic m_finish();
    m_ph = P_IDLE; m_done = 1; m_hp = 0;
  endtask

  task automatic model_step();
    bit rise, fall;
    rise = fval && !m_fv;
    fall = !fval && m_fv;
    m_done = 0;
    if (rst) begin
      m_fv = 0; m_ph = P_IDLE; m_load_left = 0; m_quiet = 0; m_left = 0;
      m_burst = 0; m_hp = 0; m_cnt = '0; m_to = 0;
    end else begin
      m_fv = fval;
      case (m_ph)
        P_IDLE, P_FAULT: begin
          if (snap && burst_n != 0) m_start(1, int'(burst_n));
          else if (run)             m_start(0, 0);
        end
        P_LOAD: begin
          if (halt) m_finish();
          else begin
            m_load_left--;
            if (m_load_left == 0) begin m_ph = P_SYNC; m_quiet = 0; end
          end
        end
        P_SYNC, P_GAP: begin
          if (halt)      m_finish();
          else if (rise) m_ph = P_ACT;
          else if (fall) m_quiet = 0;
          else begin
            m_quiet++;
            if (m_quiet == TO_CYC) begin m_ph = P_FAULT; m_to = 1; end
          end
        end
        P_ACT: begin
          if (fall) begin
            m_cnt++;
            if (m_burst) m_left--;
            if (m_hp || halt || (m_burst && m_left == 0)) m_finish();
            else begin m_ph = P_GAP; m_quiet = 0; end
          end else if (halt) m_hp = 1;
        end
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  always @(posedge clk) model_step();

  function automatic logic [23:0] model_bundle();
    logic c, l, b;
    c = (m_ph == P_ACT) || (m_ph == P_GAP);
    l = (m_ph == P_LOAD);
    b = (m_ph != P_IDLE) && (m_ph != P_FAULT);
    return {c, l, m_cnt, b, m_done, m_to, 3'(m_ph)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      fval = v;
      step();
      if (done) done_seen++;
      if (!busy) busy_dropped = 1;
    end
  endtask

  task automatic pulse_run();
    run = 1'b1; step(); run = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; fval = 1'b0; run = 1'b0; snap = 1'b0; halt = 1'b0; burst_n = '0;
    step(); step();
    checks++;
    if ({cap_en, load, frame_cnt, busy, done, timeout, state} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 000000",
               {cap_en, load, frame_cnt, busy, done, timeout, state});
    end
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_continuous();
    int load_cycles;
    pulse_run();
    load_cycles = (load === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (load === 1'b1) load_cycles++; else break;
    end
    checks++;
    if (load_cycles != LOAD_LEN) begin
      errors++; $display("FAIL cont_load_len got %0d want %0d", load_cycles, LOAD_LEN);
    end
    checks++;
    if (state !== 3'd2 || cap_en !== 1'b0) begin
      errors++; $display("FAIL cont_sync_entry got state=%0d cap=%b want state=2 cap=0", state, cap_en);
    end
    fval = 1'b1; step();
    checks++;
    if (cap_en !== 1'b1) begin
      errors++; $display("FAIL cont_cap_en_after_rise got %b want 1", cap_en);
    end
    busy_dropped = 0;
    drive_level(1'b1, 99);
    drive_level(1'b0, 20);
    for (int f = 0; f < 2; f++) begin
      drive_level(1'b1, 100);
      drive_level(1'b0, 20);
    end
    exp_cnt = exp_cnt + 16'd3;
    checks++;
    if (frame_cnt !== exp_cnt) begin
      errors++; $display("FAIL cont_frame_cnt got %0d want %0d", frame_cnt, exp_cnt);
    end
    checks++;
    if (busy_dropped || state !== 3'd4 || cap_en !== 1'b1) begin
      errors++; $display("FAIL cont_busy_gap got dropped=%0d state=%0d cap=%b want 0 4 1",
                         busy_dropped, state, cap_en);
    end
    // Halt while in the inter-frame gap stops at once without counting.
    halt = 1'b1; step(); halt = 1'b0;
    checks++;
    if (state !== 3'd0 || done !== 1'b1 || cap_en !== 1'b0 || frame_cnt !== exp_cnt) begin
      errors++; $display("FAIL gap_halt got state=%0d done=%b cap=%b cnt=%0d want 0 1 0 %0d",
                         state, done, cap_en, frame_cnt, exp_cnt);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL gap_halt_done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_burst();
    int h;
    snap = 1'b1; burst_n = 8'd2; step(); snap = 1'b0; burst_n = '0;
    drive_level(1'b0, 6);
    h = $urandom_range(5, 40);
    drive_level(1'b1, h);
    drive_level(1'b0, $urandom_range(3, 20));
    exp_cnt++;
    checks++;
    if (state !== 3'd4 || frame_cnt !== exp_cnt) begin
      errors++; $display("FAIL burst_first_frame got state=%0d cnt=%0d want 4 %0d", state, frame_cnt, exp_cnt);
    end
    drive_level(1'b1, $urandom_range(5, 40));
    fval = 1'b0; step();
    exp_cnt++;
    checks++;
    if (state !== 3'd0 || done !== 1'b1 || cap_en !== 1'b0 || frame_cnt !== exp_cnt) begin
      errors++; $display("FAIL burst_end got state=%0d done=%b cap=%b cnt=%0d want 0 1 0 %0d",
                         state, done, cap_en, frame_cnt, exp_cnt);
    end
    done_seen = 0;
    drive_level(1'b0, 3);
    drive_level(1'b1, $urandom_range(5, 40));
    drive_level(1'b0, 5);
    checks++;
    if (done_seen != 0 || frame_cnt !== exp_cnt || state !== 3'd0) begin
      errors++; $display("FAIL burst_third_frame got done_seen=%0d cnt=%0d state=%0d want 0 %0d 0",
                         done_seen, frame_cnt, state, exp_cnt);
    end
  endtask

  task automatic test_snap_midframe();
    drive_level(1'b1, 10);
    snap = 1'b1; burst_n = 8'd1; step(); snap = 1'b0; burst_n = '0;
    drive_level(1'b1, 20);
    drive_level(1'b0, 5);
    checks++;
    if (state !== 3'd2 || cap_en !== 1'b0 || frame_cnt !== exp_cnt) begin
      errors++; $display("FAIL mid_partial_skipped got state=%0d cap=%b cnt=%0d want 2 0 %0d",
                         state, cap_en, frame_cnt, exp_cnt);
    end
    fval = 1'b1; step();
    checks++;
    if (cap_en !== 1'b1 || state !== 3'd3) begin
      errors++; $display("FAIL mid_cap_after_rise got cap=%b state=%0d want 1 3", cap_en, state);
    end
    drive_level(1'b1, $urandom_range(10, 50));
    fval = 1'b0; step();
    exp_cnt++;
    checks++;
    if (state !== 3'd0 || done !== 1'b1 || frame_cnt !== exp_cnt) begin
      errors++; $display("FAIL mid_full_frame got state=%0d done=%b cnt=%0d want 0 1 %0d",
                         state, done, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_halt_active();
    pulse_run();
    drive_level(1'b0, 6);
    drive_level(1'b1, 10);
    halt = 1'b1; step(); halt = 1'b0;
    checks++;
    if (state !== 3'd3 || cap_en !== 1'b1) begin
      errors++; $display("FAIL halt_active_continues got state=%0d cap=%b want 3 1", state, cap_en);
    end
    drive_level(1'b1, 5);
    fval = 1'b0; step();
    exp_cnt++;
    checks++;
    if (state !== 3'd0 || done !== 1'b1 || cap_en !== 1'b0 || frame_cnt !== exp_cnt) begin
      errors++; $display("FAIL halt_active_end got state=%0d done=%b cap=%b cnt=%0d want 0 1 0 %0d",
                         state, done, cap_en, frame_cnt, exp_cnt);
    end
    // Halt coinciding with the falling edge: frame counts, single done.
    pulse_run();
    drive_level(1'b0, 6);
    drive_level(1'b1, $urandom_range(5, 30));
    fval = 1'b0; halt = 1'b1; step(); halt = 1'b0;
    exp_cnt++;
    done_seen = done ? 1 : 0;
    drive_level(1'b0, 3);
    checks++;
    if (state !== 3'd0 || done_seen != 1 || frame_cnt !== exp_cnt) begin
      errors++; $display("FAIL halt_on_fall got state=%0d dones=%0d cnt=%0d want 0 1 %0d",
                         state, done_seen, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    int sync_cycles;
    fval = 1'b0;
    pulse_run();
    sync_cycles = 0;
    done_seen = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done) done_seen++;
      if (state === 3'd2) sync_cycles++;
      else if (state !== 3'd1) break;
    end
    checks++;
    if (sync_cycles != TO_CYC) begin
      errors++; $display("FAIL timeout_sync_cycles got %0d want %0d", sync_cycles, TO_CYC);
    end
    checks++;
    if (state !== 3'd5 || timeout !== 1'b1 || done_seen != 0 || busy !== 1'b0 || cap_en !== 1'b0) begin
      errors++; $display("FAIL timeout_fault got state=%0d to=%b dones=%0d busy=%b cap=%b want 5 1 0 0 0",
                         state, timeout, done_seen, busy, cap_en);
    end
    pulse_run();
    checks++;
    if (timeout !== 1'b0 || state !== 3'd1 || load !== 1'b1) begin
      errors++; $display("FAIL timeout_restart got to=%b state=%0d load=%b want 0 1 1", timeout, state, load);
    end
    halt = 1'b1; step(); halt = 1'b0;
    checks++;
    if (state !== 3'd0 || done !== 1'b1) begin
      errors++; $display("FAIL halt_in_load got state=%0d done=%b want 0 1", state, done);
    end
  endtask

  task automatic test_priority_and_reset();
    run = 1'b1; snap = 1'b1; burst_n = 8'd1; step();
    run = 1'b0; snap = 1'b0; burst_n = '0;
    drive_level(1'b0, 6);
    drive_level(1'b1, 8);
    fval = 1'b0; step();
    exp_cnt++;
    checks++;
    if (state !== 3'd0 || done !== 1'b1 || frame_cnt !== exp_cnt) begin
      errors++; $display("FAIL snap_beats_run got state=%0d done=%b cnt=%0d want 0 1 %0d",
                         state, done, frame_cnt, exp_cnt);
    end
    snap = 1'b1; burst_n = 8'd0; step(); snap = 1'b0;
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || load !== 1'b0) begin
      errors++; $display("FAIL snap_zero_ignored got state=%0d busy=%b load=%b want 0 0 0", state, busy, load);
    end
    pulse_run();
    drive_level(1'b0, 6);
    drive_level(1'b1, 3);
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL reset_setup_active got state=%0d want 3", state);
    end
    rst = 1'b1; step();
    exp_cnt = '0;
    checks++;
    if ({cap_en, load, frame_cnt, busy, done, timeout, state} !== 24'h0) begin
      errors++; $display("FAIL reset_in_active got %h want 000000",
                         {cap_en, load, frame_cnt, busy, done, timeout, state});
    end
    run = 1'b1; step(); run = 1'b0;
    checks++;
    if (state !== 3'd0 || load !== 1'b0) begin
      errors++; $display("FAIL start_during_reset got state=%0d load=%b want 0 0", state, load);
    end
    rst = 1'b0; fval = 1'b0; step();
  endtask

  task automatic test_random_soak();
    bit          lvl;
    int          left;
    logic [23:0] exp_b, got_b;
    rst = 1'b1; fval = 1'b0; step(); step(); rst = 1'b0;
    lvl = 0; left = 5;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (left == 0) begin
        lvl = ~lvl;
        if (lvl) left = $urandom_range(5, 40);
        else if ($urandom_range(0, 9) == 0) left = $urandom_range(60, 100);
        else left = $urandom_range(2, 15);
      end
      left--;
      fval    = lvl;
      run     = ($urandom_range(0, 99) < 3);
      snap    = ($urandom_range(0, 99) < 3);
      burst_n = 8'($urandom_range(0, 3));
      halt    = ($urandom_range(0, 99) < 2);
      rst     = ($urandom_range(0, 499) == 0);
      step();
      exp_b = model_bundle();
      got_b = {cap_en, load, frame_cnt, busy, done, timeout, state};
      checks++;
      if (got_b !== exp_b) begin
        errors++; $display("FAIL soak_cycle_%0d got %h want %h", cyc, got_b, exp_b);
      end
    end
    run = 1'b0; snap = 1'b0; halt = 1'b0; rst = 1'b0; burst_n = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_snap_midframe();
    test_halt_active();
    test_timeout();
    test_priority_and_reset();
    test_random_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit reached at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
